// File: rtl/seg_scan_counter_if.sv
// Control and display bundle for seg_scan_counter.
// The master side drives count control and observes the display;
// the slave side is the counter/driver itself.
interface seg_scan_counter_if #(
  parameter int DIGITS = 6
);
  logic                  en;
  logic                  up_dn;
  logic                  clr;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  wrap;
  logic [DIGITS-1:0]     seg_sel;
  logic [7:0]            seg_ment;

  modport master (
    output en, up_dn, clr,
    input  count_bcd, wrap, seg_sel, seg_ment
  );

  modport slave (
    input  en, up_dn, clr,
    output count_bcd, wrap, seg_sel, seg_ment
  );
endinterface

// File: rtl/seg_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed, active-low
// seven-segment driver for a common-anode display. A prescaler turns clk
// into a count tick; a free-running scan engine walks a one-cold digit
// select across the digits and registers the matching segment code.
module seg_scan_counter #(
  parameter int DIGITS   = 6,
  parameter int TICK_CYC = 50_000_000,
  parameter int SCAN_CYC = 50_000,
  parameter int BLANK_LZ = 0
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_counter_if.slave bus
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = 4 * DIGITS;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SCAN_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_RST    = ~DIGITS'(1);

  // Active-low segment code; bit 7 is the decimal point, kept dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hc0;
      4'd1:    s = 8'hf9;
      4'd2:    s = 8'ha4;
      4'd3:    s = 8'hb0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hf8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hff;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     presc;
  logic              tick;
  logic [CW-1:0]     cnt_p0;
  logic [CW-1:0]     cnt_nxt;
  logic              wrap_p0;
  logic              carry;
  logic              carry_out;
  logic [3:0]        dig;
  logic [SW-1:0]     slot;
  logic [IW-1:0]     idx;
  logic [3:0]        cur_dig;
  logic              cur_blank;
  logic              hi_zero;
  logic [7:0]        ment_nxt;
  logic [DIGITS-1:0] sel_nxt;
  logic [DIGITS-1:0] sel_p1;
  logic [7:0]        ment_p1;

  // Prescaler: counts while enabled, holds while disabled, cleared by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc <= '0;
    else if (bus.clr)
      presc <= '0;
    else if (bus.en)
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
  end

  // en is part of the tick so a disable on the terminal cycle drops that tick.
  assign tick = bus.en && (presc == PRESC_LAST);

  // Ripple carry/borrow across the BCD digits; carry out of the top digit is a wrap.
  always_comb begin
    cnt_nxt   = cnt_p0;
    carry     = 1'b1;
    dig       = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = cnt_p0[4*k +: 4];
      if (carry) begin
        if (bus.up_dn) begin
          if (dig >= 4'd9) begin
            cnt_nxt[4*k +: 4] = 4'd0;
          end else begin
            cnt_nxt[4*k +: 4] = dig + 4'd1;
            carry             = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            cnt_nxt[4*k +: 4] = 4'd9;
          end else begin
            cnt_nxt[4*k +: 4] = dig - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
    carry_out = carry;
  end

  // Count stage: clr beats tick; wrap is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0  <= '0;
      wrap_p0 <= 1'b0;
    end else if (bus.clr) begin
      cnt_p0  <= '0;
      wrap_p0 <= 1'b0;
    end else if (tick) begin
      cnt_p0  <= cnt_nxt;
      wrap_p0 <= carry_out;
    end else begin
      wrap_p0 <= 1'b0;
    end
  end

  // Scan engine: free-running slot timer advancing the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Pick the scanned digit, apply leading-zero blanking and build the select.
  always_comb begin
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    hi_zero   = 1'b1;
    sel_nxt   = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (cnt_p0[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        cur_dig    = cnt_p0[4*k +: 4];
        cur_blank  = (BLANK_LZ != 0) && (k > 0) && hi_zero;
        sel_nxt[k] = 1'b0;
      end
    end
    ment_nxt = cur_blank ? 8'hff : seg_decode(cur_dig);
  end

  // Display stage: select and segments share one register edge so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_p1  <= SEL_RST;
      ment_p1 <= 8'hc0;
    end else begin
      sel_p1  <= sel_nxt;
      ment_p1 <= ment_nxt;
    end
  end

  assign bus.count_bcd = cnt_p0;
  assign bus.wrap      = wrap_p0;
  assign bus.seg_sel   = sel_p1;
  assign bus.seg_ment  = ment_p1;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed bench for seg_scan_counter: DIGITS=3, TICK_CYC=4, SCAN_CYC=2.
// A second instance with leading-zero blanking shares the same controls.
module tb_seg_scan_counter;
  localparam int DIGITS = 3;
  localparam int TICK   = 4;
  localparam int SCAN   = 2;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_counter_if #(.DIGITS(DIGITS)) bus ();
  seg_scan_counter_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_b.en    = bus.en;
  assign bus_b.up_dn = bus.up_dn;
  assign bus_b.clr   = bus.clr;

  seg_scan_counter #(.DIGITS(DIGITS), .TICK_CYC(TICK), .SCAN_CYC(SCAN), .BLANK_LZ(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_scan_counter #(.DIGITS(DIGITS), .TICK_CYC(TICK), .SCAN_CYC(SCAN), .BLANK_LZ(1)) u_blk (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    step(n * TICK);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
  endtask

  // Wait for the first cycle of digit 0's slot; ok=0 if it never shows.
  task automatic sync_slot0(output bit ok);
    logic [DIGITS-1:0] prev;
    ok   = 1'b0;
    prev = bus.seg_sel;
    for (int i = 0; i < 16 && !ok; i++) begin
      step(1);
      if (bus.seg_sel == 3'b110 && prev != 3'b110) ok = 1'b1;
      prev = bus.seg_sel;
    end
  endtask

  task automatic test_reset_state();
    step(2);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL rst_count: got %h want 000", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.seg_sel !== 3'b110) $display("FAIL rst_sel: got %b want 110", bus.seg_sel); else pass_cnt++;
    chk_cnt++; if (bus.seg_ment !== 8'hc0) $display("FAIL rst_ment: got %h want c0", bus.seg_ment); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL rst_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    rst    = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.up_dn = 1'b1;
    do_clr();
    run_ticks(57);
    chk_cnt++; if (bus.count_bcd !== 12'h057) $display("FAIL pre_rst_057: got %h want 057", bus.count_bcd); else pass_cnt++;
    step(2);
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL async_rst_count: got %h want 000", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.seg_sel !== 3'b110) $display("FAIL async_rst_sel: got %b want 110", bus.seg_sel); else pass_cnt++;
    chk_cnt++; if (bus.seg_ment !== 8'hc0) $display("FAIL async_rst_ment: got %h want c0", bus.seg_ment); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL async_rst_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    step(3);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL post_rst_3cyc: got %h want 000", bus.count_bcd); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.count_bcd !== 12'h001) $display("FAIL post_rst_4cyc: got %h want 001", bus.count_bcd); else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    bus.up_dn = 1'b1;
    do_clr();
    run_ticks(99);
    chk_cnt++; if (bus.count_bcd !== 12'h099) $display("FAIL up_099: got %h want 099", bus.count_bcd); else pass_cnt++;
    run_ticks(1);
    chk_cnt++; if (bus.count_bcd !== 12'h100) $display("FAIL up_100: got %h want 100", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL up_100_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    run_ticks(898);
    chk_cnt++; if (bus.count_bcd !== 12'h998) $display("FAIL up_998: got %h want 998", bus.count_bcd); else pass_cnt++;
    run_ticks(1);
    chk_cnt++; if (bus.count_bcd !== 12'h999) $display("FAIL up_999: got %h want 999", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL up_999_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    run_ticks(1);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL up_wrap_000: got %h want 000", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b1) $display("FAIL up_wrap_pulse: got %b want 1", bus.wrap); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL up_wrap_end: got %b want 0", bus.wrap); else pass_cnt++;
  endtask

  task automatic test_down_wrap();
    bus.up_dn = 1'b0;
    do_clr();
    run_ticks(1);
    chk_cnt++; if (bus.count_bcd !== 12'h999) $display("FAIL dn_999: got %h want 999", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b1) $display("FAIL dn_wrap_pulse: got %b want 1", bus.wrap); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL dn_wrap_end: got %b want 0", bus.wrap); else pass_cnt++;
    step(3);
    chk_cnt++; if (bus.count_bcd !== 12'h998) $display("FAIL dn_998: got %h want 998", bus.count_bcd); else pass_cnt++;
    bus.up_dn = 1'b1;
    do_clr();
    run_ticks(100);
    bus.up_dn = 1'b0;
    run_ticks(1);
    chk_cnt++; if (bus.count_bcd !== 12'h099) $display("FAIL dn_099: got %h want 099", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL dn_099_wrap: got %b want 0", bus.wrap); else pass_cnt++;
  endtask

  task automatic test_enable();
    bus.up_dn = 1'b1;
    do_clr();
    step(2);
    bus.en = 1'b0;
    step(10);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL en_frozen: got %h want 000", bus.count_bcd); else pass_cnt++;
    bus.en = 1'b1;
    step(1);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL en_resume_1: got %h want 000", bus.count_bcd); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.count_bcd !== 12'h001) $display("FAIL en_resume_tick: got %h want 001", bus.count_bcd); else pass_cnt++;
  endtask

  task automatic test_clr_tick();
    bus.up_dn = 1'b1;
    do_clr();
    run_ticks(41);
    chk_cnt++; if (bus.count_bcd !== 12'h041) $display("FAIL clr_pre_041: got %h want 041", bus.count_bcd); else pass_cnt++;
    step(3);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL clr_tick_count: got %h want 000", bus.count_bcd); else pass_cnt++;
    chk_cnt++; if (bus.wrap !== 1'b0) $display("FAIL clr_tick_wrap: got %b want 0", bus.wrap); else pass_cnt++;
    step(3);
    chk_cnt++; if (bus.count_bcd !== 12'h000) $display("FAIL clr_presc_3: got %h want 000", bus.count_bcd); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.count_bcd !== 12'h001) $display("FAIL clr_presc_4: got %h want 001", bus.count_bcd); else pass_cnt++;
  endtask

  task automatic test_scan();
    bit         ok;
    logic [2:0] es [3];
    logic [7:0] em [3];
    es = '{3'b110, 3'b101, 3'b011};
    em = '{8'hb0, 8'ha4, 8'hf9};
    bus.up_dn = 1'b1;
    do_clr();
    run_ticks(123);
    bus.en = 1'b0;
    step(2);
    chk_cnt++; if (bus.count_bcd !== 12'h123) $display("FAIL scan_count: got %h want 123", bus.count_bcd); else pass_cnt++;
    sync_slot0(ok);
    chk_cnt++;
    if (!ok) begin
      $display("FAIL scan_sync: got no slot-0 start want one within 16 cycles");
    end else begin
      pass_cnt++;
      for (int j = 0; j < 6; j++) begin
        chk_cnt++; if (bus.seg_sel !== es[j/2]) $display("FAIL scan_sel_c%0d: got %b want %b", j, bus.seg_sel, es[j/2]); else pass_cnt++;
        chk_cnt++; if (bus.seg_ment !== em[j/2]) $display("FAIL scan_ment_c%0d: got %h want %h", j, bus.seg_ment, em[j/2]); else pass_cnt++;
        step(1);
      end
      chk_cnt++; if (bus.seg_sel !== 3'b110) $display("FAIL scan_return: got %b want 110", bus.seg_sel); else pass_cnt++;
    end
    bus.en = 1'b1;
  endtask

  task automatic test_blanking();
    bit         ok;
    int         nt [3];
    logic [7:0] eb [3][3];
    logic [7:0] en_tab [3][3];
    logic [2:0] es [3];
    nt     = '{0, 5, 105};
    eb     = '{'{8'hc0, 8'hff, 8'hff}, '{8'h92, 8'hff, 8'hff}, '{8'h92, 8'hc0, 8'hf9}};
    en_tab = '{'{8'hc0, 8'hc0, 8'hc0}, '{8'h92, 8'hc0, 8'hc0}, '{8'h92, 8'hc0, 8'hf9}};
    es     = '{3'b110, 3'b101, 3'b011};
    bus.up_dn = 1'b1;
    for (int v = 0; v < 3; v++) begin
      bus.en = 1'b1;
      do_clr();
      run_ticks(nt[v]);
      bus.en = 1'b0;
      step(2);
      sync_slot0(ok);
      chk_cnt++;
      if (!ok) begin
        $display("FAIL blank_sync_v%0d: got no slot-0 start want one within 16 cycles", v);
      end else begin
        pass_cnt++;
        for (int d = 0; d < 3; d++) begin
          chk_cnt++; if (bus_b.seg_sel !== es[d]) $display("FAIL blank_sel_v%0d_d%0d: got %b want %b", v, d, bus_b.seg_sel, es[d]); else pass_cnt++;
          chk_cnt++; if (bus_b.seg_ment !== eb[v][d]) $display("FAIL blank_ment_v%0d_d%0d: got %h want %h", v, d, bus_b.seg_ment, eb[v][d]); else pass_cnt++;
          chk_cnt++; if (bus.seg_ment !== en_tab[v][d]) $display("FAIL noblank_ment_v%0d_d%0d: got %h want %h", v, d, bus.seg_ment, en_tab[v][d]); else pass_cnt++;
          step(SCAN);
        end
      end
    end
    bus.en = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.up_dn = 1'b1;
    bus.clr   = 1'b0;
    test_reset_state();
    test_reset_mid();
    test_up_wrap();
    test_down_wrap();
    test_enable();
    test_clr_tick();
    test_scan();
    test_blanking();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
